database_load_controller: RTL and testbench

//   Sequences the boot-time load of the Haar classifier parameter database. Streams three

---
 rtl/database_load_controller.sv | 173 +++++++++++++++++
 tb/tb_database_load_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/database_load_controller.sv
// Boot-time loader: streams stage ROMs 1..3 in order into the flat parameter store.
// Latency: first read the cycle after start; each word lands ROM_LATENCY cycles after its read.
// Backpressure: none -- ROM latency is fixed and the store accepts one write every cycle.
//
// Ports:
//   clk, reset (async, active-low)
//   i_start                  : request (re)load; honoured only in IDLE or DONE
//   o_busy / o_load_done     : load in progress / whole database valid (level)
//   o_stage_done[2:0]        : sticky per-stage done, [0] = stage 1
//   o_rom_sel/ren/addr       : stage ROM select, read enable, word address
//   i_rom_data               : ROM read data, ROM_LATENCY cycles after o_rom_ren
//   o_wen/o_waddr/o_wdata    : parameter-store write port
module database_load_controller #(
  parameter int ADDR_WIDTH               = 10,
  parameter int DATA_WIDTH_12            = 12,
  parameter int DATA_WIDTH_16            = 16,
  parameter int NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int NUM_STAGE_THRESHOLD      = 3,
  parameter int NUM_CLASSIFIERS_STAGE_1  = 10,
  parameter int NUM_CLASSIFIERS_STAGE_2  = 10,
  parameter int NUM_CLASSIFIERS_STAGE_3  = 10,
  parameter int ROM_LATENCY              = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_load_done,
  output logic [2:0]               o_stage_done,
  output logic [1:0]               o_rom_sel,
  output logic                     o_rom_ren,
  output logic [ADDR_WIDTH-1:0]    o_rom_addr,
  input  logic [DATA_WIDTH_16-1:0] i_rom_data,
  output logic                     o_wen,
  output logic [DATA_WIDTH_12-1:0] o_waddr,
  output logic [DATA_WIDTH_16-1:0] o_wdata
);

  localparam int SIZE_STAGE_1 = NUM_CLASSIFIERS_STAGE_1 * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
  localparam int SIZE_STAGE_2 = NUM_CLASSIFIERS_STAGE_2 * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
  localparam int SIZE_STAGE_3 = NUM_CLASSIFIERS_STAGE_3 * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
  localparam int TOTAL_SIZE   = SIZE_STAGE_1 + SIZE_STAGE_2 + SIZE_STAGE_3;

  localparam logic [ADDR_WIDTH-1:0] LAST_1 = ADDR_WIDTH'(SIZE_STAGE_1 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_2 = ADDR_WIDTH'(SIZE_STAGE_2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_3 = ADDR_WIDTH'(SIZE_STAGE_3 - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state;
  state_t                  nxt_state;
  logic                    nxt_ren;
  logic [1:0]              nxt_sel;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic                    nxt_last;
  logic                    start_ok;

  // Reads in flight. Stage 0 is loaded together with o_rom_ren, so stage
  // ROM_LATENCY-1 is valid exactly when i_rom_data is ready to be captured.
  logic [ROM_LATENCY-1:0]  pipe_vld;
  logic [ROM_LATENCY-1:0]  pipe_last;
  logic [1:0]              pipe_sel [ROM_LATENCY];

  logic [DATA_WIDTH_12-1:0] wcnt;
  logic                     wr_last;
  logic [1:0]               wr_sel;

  function automatic logic [ADDR_WIDTH-1:0] stage_last(input logic [1:0] sel);
    case (sel)
      2'd0:    return LAST_1;
      2'd1:    return LAST_2;
      default: return LAST_3;
    endcase
  endfunction

  // Next read request: address walks each stage, then hops to the next ROM.
  always_comb begin
    nxt_state = state;
    nxt_ren   = 1'b0;
    nxt_sel   = o_rom_sel;
    nxt_addr  = o_rom_addr;
    start_ok  = i_start && (state == IDLE || state == DONE);
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          nxt_state = ISSUE;
          nxt_ren   = 1'b1;
          nxt_sel   = 2'd0;
          nxt_addr  = '0;
        end
      end
      ISSUE: begin
        if (o_rom_addr == stage_last(o_rom_sel)) begin
          if (o_rom_sel == 2'd2) begin
            nxt_state = DRAIN;
          end else begin
            nxt_ren  = 1'b1;
            nxt_sel  = o_rom_sel + 2'd1;
            nxt_addr = '0;
          end
        end else begin
          nxt_ren  = 1'b1;
          nxt_addr = o_rom_addr + 1'b1;
        end
      end
      DRAIN: begin
        if (pipe_vld == '0) nxt_state = DONE;
      end
      default: nxt_state = IDLE;
    endcase
    nxt_last = nxt_ren && (nxt_addr == stage_last(nxt_sel));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_load_done  <= 1'b0;
      o_stage_done <= '0;
      o_rom_sel    <= '0;
      o_rom_ren    <= 1'b0;
      o_rom_addr   <= '0;
      o_wen        <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      pipe_vld     <= '0;
      pipe_last    <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) pipe_sel[i] <= '0;
      wcnt         <= '0;
      wr_last      <= 1'b0;
      wr_sel       <= '0;
    end else begin
      state      <= nxt_state;
      o_rom_ren  <= nxt_ren;
      o_rom_sel  <= nxt_sel;
      o_rom_addr <= nxt_addr;

      pipe_vld[0]  <= nxt_ren;
      pipe_last[0] <= nxt_last;
      pipe_sel[0]  <= nxt_sel;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_sel[i]  <= pipe_sel[i-1];
      end

      // Write stage: capture ROM data as the matching read leaves the pipe.
      o_wen   <= pipe_vld[ROM_LATENCY-1];
      wr_last <= pipe_vld[ROM_LATENCY-1] && pipe_last[ROM_LATENCY-1];
      wr_sel  <= pipe_sel[ROM_LATENCY-1];
      if (pipe_vld[ROM_LATENCY-1]) begin
        o_wdata <= i_rom_data;
        o_waddr <= wcnt;
        wcnt    <= wcnt + 1'b1;
      end

      if (start_ok) begin
        o_busy       <= 1'b1;
        o_load_done  <= 1'b0;
        o_stage_done <= '0;
        wcnt         <= '0;
      end else begin
        // Stage bit rises the cycle after that stage's final word is on the port.
        if (o_wen && wr_last) o_stage_done[wr_sel] <= 1'b1;
        if (state == DRAIN && pipe_vld == '0) begin
          o_busy      <= 1'b0;
          o_load_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_database_load_controller.sv
// Bench for database_load_controller: three instances (ROM_LATENCY 1, 2, 4) run in lockstep.
// Each instance gets a ROM model returning {sel,addr}; a negedge monitor tallies every write.
module tb_database_load_controller;

  localparam int TOTAL = 579;

  logic clk = 1'b0;
  logic rst_n;
  logic i_start;
  logic clr;
  int   cyc = 0;
  int   st;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        busy_s  [3];
  logic        done_s  [3];
  logic [2:0]  sd_s    [3];
  logic [1:0]  sel_s   [3];
  logic        ren_s   [3];
  logic [9:0]  raddr_s [3];
  logic [15:0] rdata_s [3];
  logic        wen_s   [3];
  logic [11:0] waddr_s [3];
  logic [15:0] wdata_s [3];

  logic [15:0] rh [3][8];

  int          nwr [3], bad [3], gaps [3], busy_n [3];
  int          first_wen [3], last_wen [3], done_rise [3];
  logic        prev_wen [3], prev_done [3], after192 [3];
  logic [2:0]  sd192 [3];
  logic [15:0] w192 [3], w193 [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  // Expected store image: stage words in ROM address order, tagged {sel,addr}.
  function automatic logic [15:0] img(input int n);
    if (n < 193)      return {6'd0, 10'(n)};
    else if (n < 386) return {4'd0, 2'd1, 10'(n - 193)};
    else              return {4'd0, 2'd2, 10'(n - 386)};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    database_load_controller #(.ROM_LATENCY((g == 0) ? 1 : (g == 1) ? 2 : 4)) dut (
      .clk          (clk),
      .reset        (rst_n),
      .i_start      (i_start),
      .o_busy       (busy_s[g]),
      .o_load_done  (done_s[g]),
      .o_stage_done (sd_s[g]),
      .o_rom_sel    (sel_s[g]),
      .o_rom_ren    (ren_s[g]),
      .o_rom_addr   (raddr_s[g]),
      .i_rom_data   (rdata_s[g]),
      .o_wen        (wen_s[g]),
      .o_waddr      (waddr_s[g]),
      .o_wdata      (wdata_s[g])
    );
  end

  // ROM model: data for the read presented in cycle c is visible in cycle c+L-1,
  // so the DUT captures it on the L-th edge after the read.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      rh[g][0] <= {4'd0, sel_s[g], raddr_s[g]};
      for (int i = 1; i < 8; i++) rh[g][i] <= rh[g][i-1];
    end
  end

  always_comb begin
    for (int g = 0; g < 3; g++) begin
      rdata_s[g] = (lat(g) == 1) ? {4'd0, sel_s[g], raddr_s[g]} : rh[g][(lat(g) > 1) ? lat(g) - 2 : 0];
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (clr) begin
        nwr[g] <= 0; bad[g] <= 0; gaps[g] <= 0; busy_n[g] <= 0;
        first_wen[g] <= 0; last_wen[g] <= 0; done_rise[g] <= 0;
        prev_wen[g] <= 1'b0; prev_done[g] <= 1'b0; after192[g] <= 1'b0;
        sd192[g] <= '0; w192[g] <= '0; w193[g] <= '0;
      end else begin
        if (busy_s[g]) busy_n[g] <= busy_n[g] + 1;
        if (after192[g]) begin
          sd192[g]    <= sd_s[g];
          after192[g] <= 1'b0;
        end
        if (wen_s[g]) begin
          if (nwr[g] > 0 && !prev_wen[g]) gaps[g] <= gaps[g] + 1;
          if (nwr[g] == 0) first_wen[g] <= cyc;
          last_wen[g] <= cyc;
          if (waddr_s[g] !== 12'(nwr[g]) || wdata_s[g] !== img(nwr[g])) bad[g] <= bad[g] + 1;
          if (nwr[g] == 192) begin
            w192[g]     <= wdata_s[g];
            after192[g] <= 1'b1;
          end
          if (nwr[g] == 193) w193[g] <= wdata_s[g];
          nwr[g] <= nwr[g] + 1;
        end
        if (done_s[g] && !prev_done[g]) done_rise[g] <= cyc;
        prev_wen[g]  <= wen_s[g];
        prev_done[g] <= done_s[g];
      end
    end
  end

  task automatic chk_eq(input string tag, input int g, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[lat=%0d]: got %0d expected %0d", tag, lat(g), got, exp);
    end
  endtask

  // Clear the tallies, then pulse i_start for one edge; st = cycle index of the capturing edge.
  task automatic start_load();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    i_start = 1'b1;
    st = cyc + 1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!(done_s[0] && done_s[1] && done_s[2]) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) chk_eq("done_timeout", 2, 0, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (nwr[1] < n && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 2000) chk_eq("write_timeout", 1, 0, 1);
  endtask

  task automatic check_load(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk_eq({tag, "_count"},     g, nwr[g],       TOTAL);
      chk_eq({tag, "_bad_words"}, g, bad[g],       0);
      chk_eq({tag, "_gaps"},      g, gaps[g],      0);
      chk_eq({tag, "_first_wen"}, g, first_wen[g], st + lat(g));
      chk_eq({tag, "_last_wen"},  g, last_wen[g],  st + TOTAL - 1 + lat(g));
      chk_eq({tag, "_done_rise"}, g, done_rise[g], st + TOTAL + lat(g));
      chk_eq({tag, "_busy_len"},  g, busy_n[g],    TOTAL + lat(g));
      chk_eq({tag, "_stage_all"}, g, sd_s[g],      3'b111);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk_eq({tag, "_busy"},  g, busy_s[g],  0);
      chk_eq({tag, "_done"},  g, done_s[g],  0);
      chk_eq({tag, "_stage"}, g, sd_s[g],    0);
      chk_eq({tag, "_ren"},   g, ren_s[g],   0);
      chk_eq({tag, "_wen"},   g, wen_s[g],   0);
      chk_eq({tag, "_waddr"}, g, waddr_s[g], 0);
      chk_eq({tag, "_wdata"}, g, wdata_s[g], 0);
      chk_eq({tag, "_raddr"}, g, raddr_s[g], 0);
      chk_eq({tag, "_rsel"},  g, sel_s[g],   0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    clr     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Plain load plus stage-1/stage-2 boundary.
    start_load();
    wait_done();
    check_load("load1");
    for (int g = 0; g < 3; g++) begin
      chk_eq("w192", g, w192[g], 16'h00C0);
      chk_eq("w193", g, w193[g], 16'h0400);
      chk_eq("stage_after192", g, sd192[g], 3'b001);
    end

    // Start pulse in the middle of ISSUE must be ignored.
    start_load();
    wait_writes(100);
    i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_done();
    check_load("midstart");

    // Restart from DONE: load_done and stage bits drop right after the start edge.
    start_load();
    for (int g = 0; g < 3; g++) begin
      chk_eq("restart_done", g, done_s[g], 0);
      chk_eq("restart_busy", g, busy_s[g], 1);
      chk_eq("restart_stage", g, sd_s[g], 0);
    end
    wait_done();
    check_load("reload");

    // Asynchronous reset in mid-load, then a clean full load.
    start_load();
    wait_writes(300);
    #2 rst_n = 1'b0;
    #1;
    check_zero("abort");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    start_load();
    wait_done();
    check_load("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
